mem_io_responder: RTL and testbench
===================================

# mem_io_responder

Responder end of the byte-wide memory bus driven by the CPU memory controller. Serves byte reads and writes to a synchronous on-chip RAM. Decodes the IO window at 0x30000–0x30007: a UART transmit FIFO, a one-byte receive holding register, and a halt port. Generates the `io_buffer_full` back-pressure signal the controller checks before starting a transaction.

## Interface
- `ADDR_WIDTH`, 17: RAM byte-address bits (RAM size 2^ADDR_WIDTH bytes).
- `TX_DEPTH`, 8: UART TX FIFO entries; power of two, ≥4.
- `clk_in` in 1: system clock.
- `rst_n_in` in 1: reset, asynchronous, active-low.
- `rdy_in` in 1: global ready; when low, no bus-side state changes.
- `bus_a` in 32: byte address; bits 17:0 are decoded.
- `bus_wdata` in 8: write byte.
- `bus_wr` in 1: 1 = write, 0 = read.
- `bus_rdata` out 8: registered read byte.
- `io_buffer_full` out 1: TX FIFO near full.
- `tx_data` out 8: FIFO head byte.
- `tx_valid` out 1: FIFO non-empty.
- `tx_ready` in 1: UART accepts head byte this cycle.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: `rx_data` valid.
- `rx_ready` out 1: holding register empty.
- `tx_overflow` out 1: sticky; set when a push hits a full FIFO.
- `sim_done` out 1: one-cycle pulse on a halt-port write.

## Operation
- **Decode.** `io_sel = (bus_a[17:16] == 2'b11)`. RAM index is `bus_a[ADDR_WIDTH-1:0]` when `!io_sel`.
- **RAM write.** At a posedge with `rdy_in && bus_wr && !io_sel`, write `bus_wdata` to RAM.
- **RAM read.** At a posedge with `rdy_in && !bus_wr && !io_sel`, load `bus_rdata` from RAM at the index.
  - Read-during-write is not possible, since `bus_wr` selects one operation per cycle.
- **IO write to 0x30000.** Push `bus_wdata` into the TX FIFO.
  - If the FIFO is full, drop the byte and set `tx_overflow`.
- **IO write to 0x30004.** Pulse `sim_done` for one cycle.
- **IO write to other IO addresses.** Ignored.
- **IO read from 0x30000.**
  - `bus_rdata` ← holding byte if full, else 0x00.
  - Clear the holding register (pop).
- **IO read from 0x30004.** `bus_rdata` ← `{7'b0, tx FIFO empty}`.
- **IO read from other IO addresses.** `bus_rdata` ← 0x00.
- **RX holding register.**
  - `rx_ready = !full`.
  - Load `rx_data` and set full when `rx_valid && rx_ready`.
  - A pop and a load in the same cycle are impossible, because the pop requires full.
- **TX FIFO.**
  - Circular buffer; pointers are log2(TX_DEPTH) bits and wrap modulo TX_DEPTH.
  - Occupancy `count` is log2(TX_DEPTH)+1 bits.
  - A pop occurs when `tx_valid && tx_ready`, independent of `rdy_in`.
  - Push and pop in the same cycle: both occur and `count` is unchanged; a push to a full FIFO with a simultaneous pop is accepted.
- **`io_buffer_full`.** Equals `count >= TX_DEPTH-2`; the controller may have one store in flight, so this leaves headroom.
- **`rdy_in` low.**
  - No RAM write, FIFO push, RX pop or `sim_done`.
  - `bus_rdata` holds.
  - TX drain and RX load continue.

## Timing
- Read latency is 1 cycle: address presented in cycle N, `bus_rdata` valid throughout cycle N+1, matching the controller sampling the byte one cycle after driving the address.
- Write takes effect at the posedge ending the cycle in which it is presented.
- `tx_data`/`tx_valid` reflect a push on the cycle after it.
- `io_buffer_full` is derived from registered `count`, so it updates one cycle after the push or pop.
- Reset values:
  - `bus_rdata` = 0, `tx_valid` = 0, `io_buffer_full` = 0, `tx_overflow` = 0, `sim_done` = 0, `rx_ready` = 1.
  - FIFO pointers and `count` = 0.
  - RAM contents are not reset.
- Reset asserted mid-operation: the FIFO is flushed immediately and the held RX byte is lost.

## Configuration
- `IO_WR_DEDUP_EN`
  - **Defined:** an IO write (0x30000 or 0x30004) takes effect only on the first cycle of a run of consecutive `rdy_in`-qualified cycles with identical `bus_a`, `bus_wr` = 1 and `io_sel`. A one-bit "previous cycle was same IO write" register provides the comparison and is cleared on reset, on any read, or on an address change. This absorbs the controller holding `bus_wr` high while idle after a store.
  - **Undefined:** every qualifying cycle pushes or pulses.
  - RAM writes are unaffected either way.

## Test plan
- Write 0xA5 to 0x00010, then read 0x00010 → `bus_rdata` = 0xA5 in the cycle after the read address.
- Write bytes 0x01..0x06 to 0x30000 with `tx_ready` = 0 (TX_DEPTH = 8) → `count` = 6 and `io_buffer_full` = 1 on the cycle after the 6th push; write 0x07, 0x08, 0x09 → `tx_overflow` = 1 and 0x09 is dropped.
- Fill FIFO to 8 entries, then push and pop in the same cycle → `count` stays 8, no overflow, head advances to 0x02.
- Pulse `rx_valid` with `rx_data` = 0x3C, then read 0x30000 → `bus_rdata` = 0x3C and `rx_ready` returns to 1; a second read → 0x00.
- Hold `bus_wr` = 1 at 0x30000 with `bus_wdata` = 0x41 for 3 cycles → 1 push with `IO_WR_DEDUP_EN`, 3 pushes without.
- Deassert `rst_n_in` asynchronously mid-burst with 4 entries queued → `tx_valid` = 0 immediately; `count` = 0 and `io_buffer_full` = 0.

Source files
------------

// File: rtl/mem_io_responder.sv
// Byte-wide memory bus responder: on-chip RAM, UART TX FIFO / RX holding register, halt port.
// Optional IO_WR_DEDUP_EN collapses held IO writes into one effect.
module mem_io_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int TX_DEPTH   = 8
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    input  logic [31:0] bus_a,
    input  logic [7:0]  bus_wdata,
    input  logic        bus_wr,
    output logic [7:0]  bus_rdata,
    output logic        io_buffer_full,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        tx_overflow,
    output logic        sim_done
);

    localparam int PW = $clog2(TX_DEPTH);
    localparam logic [PW:0] CNT_FULL = (PW+1)'(TX_DEPTH);
    localparam logic [PW:0] CNT_HIGH = (PW+1)'(TX_DEPTH - 2);
    localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [15:0] OFF_TX   = 16'h0000;
    localparam logic [15:0] OFF_HALT = 16'h0004;

    logic [7:0] ram [2**ADDR_WIDTH];
    logic [7:0] tx_buf [TX_DEPTH];

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;

    logic          rx_full;
    logic [7:0]    rx_hold;

    logic          io_sel;
    logic [15:0]   io_off;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic          rd_en;
    logic          wr_en;
    logic          ram_wr;
    logic          io_wr;
    logic          io_wr_eff;
    logic          push_req;
    logic          tx_pop;
    logic          tx_full;
    logic          tx_push;
    logic          rx_pop;
    logic          rx_load;
    logic          unused_hi;

    assign io_sel   = (bus_a[17:16] == 2'b11);
    assign io_off   = bus_a[15:0];
    assign ram_idx  = bus_a[ADDR_WIDTH-1:0];
    assign rd_en    = rdy_in && !bus_wr;
    assign wr_en    = rdy_in && bus_wr;
    assign ram_wr   = wr_en && !io_sel;
    assign io_wr    = wr_en && io_sel;
    assign unused_hi = ^bus_a[31:18];

`ifdef IO_WR_DEDUP_EN
    logic        dup_q;
    logic [31:0] dup_a;

    // A held store repeats the same IO write every cycle; only the first counts.
    assign io_wr_eff = io_wr && !(dup_q && (dup_a == bus_a));

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dup_q <= 1'b0;
            dup_a <= 32'h0;
        end else if (rdy_in) begin
            dup_q <= io_wr;
            dup_a <= bus_a;
        end
    end
`else
    assign io_wr_eff = io_wr;
`endif

    assign tx_valid = (count != '0);
    assign tx_full  = (count == CNT_FULL);
    assign tx_pop   = tx_valid && tx_ready;
    assign push_req = io_wr_eff && (io_off == OFF_TX);
    assign tx_push  = push_req && (!tx_full || tx_pop);
    assign tx_data  = tx_buf[rd_ptr];
    assign io_buffer_full = (count >= CNT_HIGH);

    assign rx_ready = !rx_full;
    assign rx_pop   = rd_en && io_sel && (io_off == OFF_TX) && rx_full;
    assign rx_load  = rx_valid && !rx_full;

    always_ff @(posedge clk_in) begin
        if (ram_wr) begin
            ram[ram_idx] <= bus_wdata;
        end
    end

    always_ff @(posedge clk_in) begin
        if (tx_push) begin
            tx_buf[wr_ptr] <= bus_wdata;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (tx_push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (tx_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({tx_push, tx_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            tx_overflow <= 1'b0;
        end else if (push_req && tx_full && !tx_pop) begin
            tx_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_full <= 1'b0;
            rx_hold <= 8'h00;
        end else if (rx_pop) begin
            rx_full <= 1'b0;
        end else if (rx_load) begin
            rx_full <= 1'b1;
            rx_hold <= rx_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bus_rdata <= 8'h00;
        end else if (rd_en) begin
            unique case (1'b1)
                !io_sel:
                    bus_rdata <= ram[ram_idx];
                io_off == OFF_TX:
                    bus_rdata <= rx_full ? rx_hold : 8'h00;
                io_off == OFF_HALT:
                    bus_rdata <= {7'b0, !tx_valid};
                default:
                    bus_rdata <= 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sim_done <= 1'b0;
        end else begin
            sim_done <= io_wr_eff && (io_off == OFF_HALT);
        end
    end

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed and randomized checks of mem_io_responder against a queue-based reference model.
module tb_mem_io_responder;

    localparam int DEPTH = 8;

    logic        clk_in = 1'b0;
    logic        rst_n_in = 1'b0;
    logic        rdy_in = 1'b0;
    logic [31:0] bus_a = 32'h0;
    logic [7:0]  bus_wdata = 8'h0;
    logic        bus_wr = 1'b0;
    logic [7:0]  bus_rdata;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b0;
    logic [7:0]  rx_data = 8'h0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        tx_overflow;
    logic        sim_done;

    mem_io_responder #(.ADDR_WIDTH(17), .TX_DEPTH(DEPTH)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
        .bus_a(bus_a), .bus_wdata(bus_wdata), .bus_wr(bus_wr),
        .bus_rdata(bus_rdata), .io_buffer_full(io_buffer_full),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_overflow(tx_overflow), .sim_done(sim_done)
    );

    always #5 clk_in = ~clk_in;

    int vectors = 0;
    int miscompares = 0;

    // reference model state
    logic [7:0] q[$];
    logic [7:0] ram_m [int];
    bit         ovf_m;
    bit         rxf_m;
    logic [7:0] rxb_m;
    logic [7:0] rd_m;
    bit         rd_known;
    bit         done_m;
    bit         dd_v;
    logic [31:0] dd_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        ovf_m = 0; rxf_m = 0; rxb_m = 8'h00;
        rd_m = 8'h00; rd_known = 1; done_m = 0; dd_v = 0; dd_a = 0;
    endtask

    task automatic model_edge();
        bit pop, load, io, eff, push;
        pop  = (q.size() > 0) && tx_ready;
        load = rx_valid && !rxf_m;
        io   = (bus_a[17:16] == 2'b11);
        push = 0;
        done_m = 0;
        if (rdy_in) begin
            if (bus_wr && io) begin
                eff = 1;
`ifdef IO_WR_DEDUP_EN
                eff = !(dd_v && dd_a == bus_a);
`endif
                dd_v = 1; dd_a = bus_a;
                if (eff && bus_a[15:0] == 16'h0) begin
                    if (q.size() < DEPTH || pop) push = 1;
                    else ovf_m = 1;
                end
                if (eff && bus_a[15:0] == 16'h4) done_m = 1;
            end else begin
                dd_v = 0;
                if (bus_wr) ram_m[int'(bus_a[16:0])] = bus_wdata;
                else if (io) begin
                    if (bus_a[15:0] == 16'h0) begin
                        rd_m = rxf_m ? rxb_m : 8'h00;
                        rxf_m = 0;
                    end else if (bus_a[15:0] == 16'h4) begin
                        rd_m = {7'b0, q.size() == 0};
                    end else rd_m = 8'h00;
                    rd_known = 1;
                end else if (ram_m.exists(int'(bus_a[16:0]))) begin
                    rd_m = ram_m[int'(bus_a[16:0])];
                    rd_known = 1;
                end else rd_known = 0;
            end
        end
        if (pop) void'(q.pop_front());
        if (push) q.push_back(bus_wdata);
        if (load) begin rxf_m = 1; rxb_m = rx_data; end
    endtask

    task automatic check_all();
        if (rd_known) chk("bus_rdata", 32'(bus_rdata), 32'(rd_m));
        chk("tx_valid", 32'(tx_valid), 32'(q.size() > 0));
        if (q.size() > 0) chk("tx_data", 32'(tx_data), 32'(q[0]));
        chk("io_buffer_full", 32'(io_buffer_full), 32'(q.size() >= DEPTH - 2));
        chk("tx_overflow", 32'(tx_overflow), 32'(ovf_m));
        chk("rx_ready", 32'(rx_ready), 32'(!rxf_m));
        chk("sim_done", 32'(sim_done), 32'(done_m));
    endtask

    task automatic step(input logic [31:0] a, input logic w, input logic [7:0] d,
                        input logic rdy, input logic txr, input logic rxv,
                        input logic [7:0] rxd);
        bus_a = a; bus_wr = w; bus_wdata = d; rdy_in = rdy;
        tx_ready = txr; rx_valid = rxv; rx_data = rxd;
        @(posedge clk_in);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle(input logic txr);
        step(32'h0, 1'b0, 8'h0, 1'b0, txr, 1'b0, 8'h0);
    endtask

    // a RAM read between pushes breaks any held-write run
    task automatic push_b(input logic [7:0] d, input logic txr);
        step(32'h30000, 1'b1, d, 1'b1, txr, 1'b0, 8'h0);
        step(32'h00010, 1'b0, 8'h0, 1'b1, txr, 1'b0, 8'h0);
    endtask

    task automatic async_reset();
        #3;
        rst_n_in = 1'b0;
        model_reset();
        #1;
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_io_buffer_full", 32'(io_buffer_full), 32'h0);
        chk("rst_tx_overflow", 32'(tx_overflow), 32'h0);
        chk("rst_rx_ready", 32'(rx_ready), 32'h1);
        chk("rst_bus_rdata", 32'(bus_rdata), 32'h0);
        chk("rst_sim_done", 32'(sim_done), 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
    endtask

    initial begin
        int n;
        logic [31:0] a;
        model_reset();
        #2;
        chk("rst_bus_rdata", 32'(bus_rdata), 32'h0);
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_io_buffer_full", 32'(io_buffer_full), 32'h0);
        chk("rst_rx_ready", 32'(rx_ready), 32'h1);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        idle(1'b0);

        // RAM write then read
        step(32'h00010, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 8'h0);
        step(32'h00010, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h0);
        chk("ram_rd_a5", 32'(bus_rdata), 32'hA5);

        // fill toward overflow with the UART stalled
        for (int i = 1; i <= 6; i++) begin
            step(32'h30000, 1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 8'h0);
            if (i == 6) chk("full_after_6", 32'(io_buffer_full), 32'h1);
            step(32'h00010, 1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0);
        end
        for (int i = 7; i <= 9; i++) push_b(8'(i), 1'b0);
        chk("overflow_set", 32'(tx_overflow), 32'h1);
        chk("head_after_ovf", 32'(tx_data), 32'h01);

        // drain to 4 entries, then reset mid-burst
        for (int i = 0; i < 4; i++) idle(1'b1);
        chk("four_left_head", 32'(tx_data), 32'h05);
        async_reset();
        idle(1'b0);

        // full FIFO with simultaneous push and pop
        for (int i = 1; i <= 8; i++) push_b(8'(i), 1'b0);
        step(32'h30000, 1'b1, 8'h09, 1'b1, 1'b1, 1'b0, 8'h0);
        chk("pp_no_ovf", 32'(tx_overflow), 32'h0);
        chk("pp_head", 32'(tx_data), 32'h02);
        chk("pp_still_full", 32'(io_buffer_full), 32'h1);
        step(32'h30004, 1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0);
        chk("empty_flag_0", 32'(bus_rdata), 32'h0);
        for (int i = 0; i < 10; i++) idle(1'b1);

        // RX holding register
        step(32'h0, 1'b0, 8'h0, 1'b0, 1'b0, 1'b1, 8'h3C);
        chk("rx_busy", 32'(rx_ready), 32'h0);
        step(32'h30000, 1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0);
        chk("rx_byte", 32'(bus_rdata), 32'h3C);
        chk("rx_freed", 32'(rx_ready), 32'h1);
        step(32'h30000, 1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0);
        chk("rx_empty_rd", 32'(bus_rdata), 32'h00);

        // held IO store
        for (int i = 0; i < 3; i++) step(32'h30000, 1'b1, 8'h41, 1'b1, 1'b0, 1'b0, 8'h0);
        step(32'h00010, 1'b0, 8'h0, 1'b1, 1'b0, 1'b0, 8'h0);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            if (tx_valid) n++;
            idle(1'b1);
        end
`ifdef IO_WR_DEDUP_EN
        chk("held_pushes", 32'(n), 32'd1);
`else
        chk("held_pushes", 32'(n), 32'd3);
`endif

        // halt port and an unused IO address
        step(32'h30004, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h0);
        chk("halt_pulse", 32'(sim_done), 32'h1);
        step(32'h30002, 1'b1, 8'h55, 1'b1, 1'b0, 1'b0, 8'h0);
        chk("halt_once", 32'(sim_done), 32'h0);
        step(32'h30002, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h0);
        chk("other_io_rd", 32'(bus_rdata), 32'h00);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0, 1: a = 32'h30000;
                2:    a = 32'h30004;
                3:    a = 32'h30000 | 32'($urandom_range(1, 7));
                default: a = 32'h00100 + 32'($urandom_range(0, 15));
            endcase
            step(a, 1'($urandom), 8'($urandom), ($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 2) == 0), 1'($urandom), 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
